button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/ae_util_pkg.sv | 14 +
 rtl/button_chan.sv | 113 +++++++++++
 rtl/button_conditioner.sv | 68 ++++++
 tb/tb_button_conditioner.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ae_util_pkg.sv
// Shared helpers for counter sizing and tick-divider derivation.
//   cnt_width(term) : bits needed for a counter that must hold 'term' without wrapping
//   tick_term(div)  : terminal count of a divider that fires once every 'div' clocks
package ae_util_pkg;

  function automatic int unsigned cnt_width(input int unsigned term);
    return 32'($clog2(term)) + 32'd1;
  endfunction

  function automatic int unsigned tick_term(input int unsigned div);
    return div - 32'd1;
  endfunction

endpackage

// File: rtl/button_chan.sv
// One switch/button channel: 2-flop synchroniser, tick-based debounce,
// edge pulses and long-press detection.
//   clk, rstb  : clock, synchronous active-low reset
//   tick       : shared debounce tick, one clk wide
//   in         : raw asynchronous level
//   out        : debounced level
//   rise/fall  : one-clk pulses on out edges
//   long_press : one-clk pulse when out has been high C_LONG_TICKS ticks
//   long_held  : level from long_press until out falls
module button_chan
  import ae_util_pkg::*;
#(
  parameter int unsigned C_DEB_TICKS  = 10,
  parameter int unsigned C_LONG_TICKS = 1000,
  parameter bit          C_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic long_held
);

  localparam int unsigned DEB_W  = cnt_width(C_DEB_TICKS - 1);
  localparam int unsigned HOLD_W = cnt_width(C_LONG_TICKS);

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              out_q, out_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              lp_q, lp_d;
  logic              held_q, held_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // State registers
  always_ff @(posedge clk) begin
    if (!rstb) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      lp_q   <= 1'b0;
      held_q <= 1'b0;
      deb_q  <= '0;
      hold_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      lp_q   <= lp_d;
      held_q <= held_d;
      deb_q  <= deb_d;
      hold_q <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    s1_d   = in ^ C_ACTIVE_LOW;
    s2_d   = s1_q;
    out_d  = out_q;
    deb_d  = deb_q;
    hold_d = hold_q;
    lp_d   = 1'b0;

    // Any agreement, even for a single clk, restarts the debounce count
    if (s2_q == out_q) begin
      deb_d = '0;
    end else if (tick) begin
      if (deb_q == DEB_W'(C_DEB_TICKS - 1)) begin
        out_d = s2_q;
        deb_d = '0;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end

    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;

    // Hold counter saturates, so long_press can fire only once per press
    if (!out_q) begin
      hold_d = '0;
    end else if (tick && (hold_q != HOLD_W'(C_LONG_TICKS))) begin
      hold_d = hold_q + HOLD_W'(1);
      lp_d   = (hold_q == HOLD_W'(C_LONG_TICKS - 1));
    end

    if (fall_d) begin
      held_d = 1'b0;
    end else if (lp_d) begin
      held_d = 1'b1;
    end else begin
      held_d = held_q;
    end
  end

  assign out        = out_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign long_press = lp_q;
  assign long_held  = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel switch/button conditioner: shared debounce tick generator
// feeding C_CHANNELS independent button_chan instances.
//   clk, rstb  : clock, synchronous active-low reset
//   in         : raw asynchronous levels
//   out        : debounced levels
//   rise/fall  : one-clk edge pulses per channel
//   long_press : one-clk pulse per channel after C_LONG_TICKS ticks high
//   long_held  : level per channel from long_press until out falls
module button_conditioner
  import ae_util_pkg::*;
#(
  parameter int unsigned C_CHANNELS   = 4,
  parameter int unsigned C_TICK_DIV   = 100_000,
  parameter int unsigned C_DEB_TICKS  = 10,
  parameter int unsigned C_LONG_TICKS = 1000,
  parameter bit          C_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [C_CHANNELS-1:0] in,
  output logic [C_CHANNELS-1:0] out,
  output logic [C_CHANNELS-1:0] rise,
  output logic [C_CHANNELS-1:0] fall,
  output logic [C_CHANNELS-1:0] long_press,
  output logic [C_CHANNELS-1:0] long_held
);

  localparam int unsigned TICK_TERM = tick_term(C_TICK_DIV);
  localparam int unsigned TICK_W    = cnt_width(TICK_TERM);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_c;

  // Tick divider state
  always_ff @(posedge clk) begin
    if (!rstb) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Tick is decoded from the terminal count, so the first one lands on
  // the C_TICK_DIV-th clk after reset release
  always_comb begin
    tick_c     = (tick_cnt_q == TICK_W'(TICK_TERM));
    tick_cnt_d = tick_c ? '0 : (tick_cnt_q + TICK_W'(1));
  end

  for (genvar g = 0; g < int'(C_CHANNELS); g++) begin : g_chan
    button_chan #(
      .C_DEB_TICKS (C_DEB_TICKS),
      .C_LONG_TICKS(C_LONG_TICKS),
      .C_ACTIVE_LOW(C_ACTIVE_LOW)
    ) u_chan (
      .clk       (clk),
      .rstb      (rstb),
      .tick      (tick_c),
      .in        (in[g]),
      .out       (out[g]),
      .rise      (rise[g]),
      .fall      (fall[g]),
      .long_press(long_press[g]),
      .long_held (long_held[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (active-high and active-low
// inputs) compared every clk against an arithmetic reference model, plus
// directed scenarios with hand-computed expectations.
module tb_button_conditioner;

  localparam int DIV  = 4;
  localparam int DEB  = 3;
  localparam int LONG = 5;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [1:0] in_a = 2'b00;
  logic [1:0] in_b = 2'b11;
  logic [1:0] out_a, rise_a, fall_a, lp_a, held_a;
  logic [1:0] out_b, rise_b, fall_b, lp_b, held_b;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  bit b_activity = 1'b0;

  always #5 clk = ~clk;

  button_conditioner #(
    .C_CHANNELS(2), .C_TICK_DIV(DIV), .C_DEB_TICKS(DEB),
    .C_LONG_TICKS(LONG), .C_ACTIVE_LOW(1'b0)
  ) u_dut_a (
    .clk(clk), .rstb(rstb), .in(in_a), .out(out_a), .rise(rise_a),
    .fall(fall_a), .long_press(lp_a), .long_held(held_a)
  );

  button_conditioner #(
    .C_CHANNELS(2), .C_TICK_DIV(DIV), .C_DEB_TICKS(DEB),
    .C_LONG_TICKS(LONG), .C_ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .clk(clk), .rstb(rstb), .in(in_b), .out(out_b), .rise(rise_b),
    .fall(fall_b), .long_press(lp_b), .long_held(held_b)
  );

  // ---------------- reference model ----------------
  // k = clk edges since reset release; ticks fall on edges where k % DIV == 0.
  // out flips once DEB ticks have landed inside an unbroken disagreement run;
  // long_press fires when LONG ticks have landed after out went high.
  int         k[2];
  logic [1:0] ms1[2], ms2[2], mout[2], mrise[2], mfall[2], mlp[2], mheld[2];
  int         dis_since[2][2];
  int         out_edge[2][2];
  bit         dis_on[2][2];

  always @(posedge clk) begin
    logic [1:0] raw;
    bit         tk;
    int         nt;
    logic       o_old;
    for (int u = 0; u < 2; u++) begin
      raw = (u == 0) ? in_a : ~in_b;
      if (!rstb) begin
        k[u] = 0;
        ms1[u] = '0; ms2[u] = '0; mout[u] = '0; mrise[u] = '0;
        mfall[u] = '0; mlp[u] = '0; mheld[u] = '0;
        for (int c = 0; c < 2; c++) begin
          dis_on[u][c] = 1'b0; dis_since[u][c] = 0; out_edge[u][c] = 0;
        end
      end else begin
        k[u] = k[u] + 1;
        tk = (k[u] % DIV) == 0;
        for (int c = 0; c < 2; c++) begin
          o_old = mout[u][c];
          mrise[u][c] = 1'b0;
          mfall[u][c] = 1'b0;
          mlp[u][c]   = 1'b0;
          if (o_old && tk && ((k[u] / DIV - out_edge[u][c] / DIV) == LONG))
            mlp[u][c] = 1'b1;
          if (ms2[u][c] != o_old) begin
            if (!dis_on[u][c]) begin
              dis_on[u][c] = 1'b1;
              dis_since[u][c] = k[u];
            end
            nt = k[u] / DIV - (dis_since[u][c] - 1) / DIV;
            if (tk && nt == DEB) begin
              mout[u][c] = ms2[u][c];
              dis_on[u][c] = 1'b0;
              if (ms2[u][c]) begin
                mrise[u][c] = 1'b1;
                out_edge[u][c] = k[u];
              end else begin
                mfall[u][c] = 1'b1;
              end
            end
          end else begin
            dis_on[u][c] = 1'b0;
          end
          if (mfall[u][c]) mheld[u][c] = 1'b0;
          else if (mlp[u][c]) mheld[u][c] = 1'b1;
        end
        ms2[u] = ms1[u];
        ms1[u] = raw;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic cmp(input string nm, input int u, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cycle %0d: got %b expected %b", nm, u, ncyc, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    ncyc++;
    cmp("out", 0, out_a, mout[0]);
    cmp("rise", 0, rise_a, mrise[0]);
    cmp("fall", 0, fall_a, mfall[0]);
    cmp("long_press", 0, lp_a, mlp[0]);
    cmp("long_held", 0, held_a, mheld[0]);
    cmp("out", 1, out_b, mout[1]);
    cmp("rise", 1, rise_b, mrise[1]);
    cmp("fall", 1, fall_b, mfall[1]);
    cmp("long_press", 1, lp_b, mlp[1]);
    cmp("long_held", 1, held_b, mheld[1]);
    if (|{out_b, rise_b, fall_b, lp_b, held_b}) b_activity = 1'b1;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, rcnt, fcnt, lcnt, rise_at, lp_at, p;
    bit got, flag;

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({out_a, rise_a, fall_a, lp_a, held_a}), 0);
    rstb = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press: latency from in, single rise, no fall
    in_a[0] = 1'b1;
    n = 0; got = 0; rcnt = 0; fcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rise_a[0]) rcnt++;
      if (fall_a[0]) fcnt++;
      if (!got && out_a[0]) begin got = 1; n = i + 1; end
    end
    chk_range("press_latency", n, 11, 14);
    chk("press_rise_count", rcnt, 1);
    chk("press_fall_count", fcnt, 0);
    in_a[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("release_out", int'(out_a[0]), 0);

    // Short pulse must be rejected
    flag = 0;
    in_a[0] = 1'b1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i == 5) in_a[0] = 1'b0;
      if (out_a[0] || rise_a[0] || fall_a[0]) flag = 1;
    end
    chk("short_pulse_quiet", int'(flag), 0);

    // Long hold on channel 1
    in_a[1] = 1'b1;
    rcnt = 0; lcnt = 0; rise_at = -100; lp_at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rise_a[1]) begin rcnt++; rise_at = i; end
      if (lp_a[1]) begin lcnt++; lp_at = i; end
    end
    chk("long_rise_count", rcnt, 1);
    chk("long_press_count", lcnt, 1);
    chk("long_press_delay", lp_at - rise_at, 20);
    chk("long_held_level", int'(held_a[1]), 1);
    in_a[1] = 1'b0;
    got = 0; flag = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fall_a[1] && !got) begin got = 1; flag = held_a[1]; end
    end
    chk("long_fall_seen", int'(got), 1);
    chk("long_held_cleared", int'(flag), 0);

    // Simultaneous rise on ch0 and fall on ch1
    in_a[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("simul_ch1_high", int'(out_a[1]), 1);
    in_a[0] = 1'b1;
    in_a[1] = 1'b0;
    got = 0; flag = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rise_a[0] && !got) begin got = 1; flag = fall_a[1]; end
    end
    chk("simul_rise_seen", int'(got), 1);
    chk("simul_same_clk", int'(flag), 1);
    in_a[0] = 1'b0;
    repeat (20) @(negedge clk);

    // Reset mid-debounce with input held through release
    in_a[0] = 1'b1;
    repeat (6) @(negedge clk);
    rstb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_mid_zero", int'({out_a, rise_a, fall_a, lp_a, held_a,
                                  out_b, rise_b, fall_b, lp_b, held_b}), 0);
    end
    rstb = 1'b1;
    n = 0; got = 0; flag = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!got && (fall_a[0] || lp_a[0])) flag = 1;
      if (!got && rise_a[0]) begin got = 1; n = i + 1; end
    end
    chk("reset_release_latency", n, 12);
    chk("reset_release_no_spurious", int'(flag), 0);
    in_a[0] = 1'b0;
    repeat (20) @(negedge clk);

    // Active-low instance: idle-high inputs stay quiet, pulling low presses
    chk("active_low_idle", int'(b_activity), 0);
    in_b[0] = 1'b0;
    n = 0; got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!got && rise_b[0]) begin got = 1; n = i + 1; end
    end
    chk_range("active_low_rise_latency", n, 11, 14);
    in_b[0] = 1'b1;
    repeat (20) @(negedge clk);

    // Randomized phase with varying bounce density and occasional resets
    for (int seg = 0; seg < 16; seg++) begin
      case (seg % 4)
        0: p = 1;
        1: p = 3;
        2: p = 12;
        default: p = 50;
      endcase
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
          if ($urandom_range(0, 99) < p) in_a[b] = ~in_a[b];
          if ($urandom_range(0, 99) < p) in_b[b] = ~in_b[b];
        end
        rstb = ($urandom_range(0, 599) != 0);
      end
    end
    rstb = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
